// File: rtl/piecewise_slope_gen.sv
// piecewise_slope_gen: captures NKNOT (x,y) breakpoints and computes the signed
// fixed-point slope Q(DT_I).(DT_D) of each of the NKNOT-1 segments. One shared
// restoring divider is reused for every segment.
// Ports:
//   clock, rst       clock, asynchronous active-high reset
//   cal_begin        start pulse, honoured only in IDLE or DONE
//   knot_x, knot_y   packed knots, knot i at [i*DSIZE +: DSIZE]
//   busy             high while a table is being computed
//   cal_valid        full slope table valid
//   delta_bus        slopes, segment i at [i*DW +: DW]
//   seg_valid        one-cycle strobe per finished segment
//   seg_idx          index of the segment on seg_delta
//   seg_delta        slope of segment seg_idx
//   err_div0         per-segment dx==0 flag
//   err_sat          per-segment saturation flag
module piecewise_slope_gen #(
  parameter int unsigned NKNOT = 16,
  parameter int unsigned DSIZE = 16,
  parameter int unsigned DT_I  = 8,
  parameter int unsigned DT_D  = 4
) (
  input  logic                                    clock,
  input  logic                                    rst,
  input  logic                                    cal_begin,
  input  logic [NKNOT*DSIZE-1:0]                  knot_x,
  input  logic [NKNOT*DSIZE-1:0]                  knot_y,
  output logic                                    busy,
  output logic                                    cal_valid,
  output logic [(NKNOT-1)*(DT_I+DT_D)-1:0]        delta_bus,
  output logic                                    seg_valid,
  output logic [((NKNOT>2)?$clog2(NKNOT-1):1)-1:0] seg_idx,
  output logic [DT_I+DT_D-1:0]                    seg_delta,
  output logic [NKNOT-2:0]                        err_div0,
  output logic [NKNOT-2:0]                        err_sat
);

  localparam int unsigned S    = NKNOT - 1;
  localparam int unsigned DW   = DT_I + DT_D;
  localparam int unsigned QW   = DSIZE + DT_D;
  localparam int unsigned SW   = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned CNTW = (QW > 1) ? $clog2(QW) : 1;
  localparam int unsigned CW   = (QW > DW) ? QW : DW;
  localparam logic [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_DIV, ST_WB, ST_DONE} state_t;

  state_t                   state_q, state_d;
  logic [NKNOT*DSIZE-1:0]   x_q, y_q;
  logic [SW-1:0]            idx_q;
  logic [DSIZE-1:0]         dx_q;
  logic                     neg_q, dyz_q;
  logic [DSIZE-1:0]         rem_q;
  logic [QW-1:0]            dvd_q;   // dividend in, quotient out
  logic [CNTW-1:0]          cnt_q;

  logic [DSIZE-1:0]         xa, xb, ya, yb, dx, dy_mag;
  logic [DSIZE:0]           dy, shifted, diff;
  logic                     q_ge, quo_big;
  logic [DW-1:0]            mag, res;
  logic                     last_seg, last_bit;

  // Knot pair selection, segment arithmetic and result shaping
  always_comb begin
    xa = '0;
    xb = '0;
    ya = '0;
    yb = '0;
    for (int unsigned i = 0; i < S; i++) begin
      if (idx_q == SW'(i)) begin
        xa = x_q[i*DSIZE +: DSIZE];
        xb = x_q[(i+1)*DSIZE +: DSIZE];
        ya = y_q[i*DSIZE +: DSIZE];
        yb = y_q[(i+1)*DSIZE +: DSIZE];
      end
    end
    dy      = {1'b0, yb} - {1'b0, ya};
    dx      = xb - xa;
    dy_mag  = dy[DSIZE] ? DSIZE'(-dy) : dy[DSIZE-1:0];
    // One restoring step: shift in the next dividend bit, subtract if it fits
    shifted = {rem_q, dvd_q[QW-1]};
    diff    = shifted - {1'b0, dx_q};
    q_ge    = (shifted >= {1'b0, dx_q});
    quo_big = (CW'(dvd_q) > CW'(MAXV));
    mag     = quo_big ? MAXV : DW'(dvd_q);
    if (dx_q == '0) begin
      res = dyz_q ? '0 : (neg_q ? -MAXV : MAXV);
    end else begin
      res = neg_q ? -mag : mag;
    end
    last_seg = (idx_q == SW'(S-1));
    last_bit = (cnt_q == CNTW'(QW-1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (cal_begin) state_d = ST_LOAD;
      ST_LOAD:          state_d = ST_DIV;
      ST_DIV:           if (last_bit) state_d = ST_WB;
      ST_WB:            state_d = last_seg ? ST_DONE : ST_LOAD;
      default:          state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      dx_q      <= '0;
      neg_q     <= 1'b0;
      dyz_q     <= 1'b0;
      rem_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      cal_valid <= 1'b0;
      delta_bus <= '0;
      seg_valid <= 1'b0;
      seg_idx   <= '0;
      seg_delta <= '0;
      err_div0  <= '0;
      err_sat   <= '0;
    end else begin
      seg_valid <= 1'b0;
      busy      <= (state_d == ST_LOAD) || (state_d == ST_DIV) || (state_d == ST_WB);
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cal_begin) begin
            x_q       <= knot_x;
            y_q       <= knot_y;
            idx_q     <= '0;
            cal_valid <= 1'b0;
            delta_bus <= '0;
            err_div0  <= '0;
            err_sat   <= '0;
          end
        end
        ST_LOAD: begin
          dx_q  <= dx;
          neg_q <= dy[DSIZE];
          dyz_q <= (dy == '0);
          dvd_q <= QW'(dy_mag) << DT_D;
          rem_q <= '0;
          cnt_q <= '0;
        end
        ST_DIV: begin
          rem_q <= q_ge ? DSIZE'(diff) : shifted[DSIZE-1:0];
          dvd_q <= {dvd_q[QW-2:0], q_ge};
          cnt_q <= cnt_q + 1'b1;
        end
        ST_WB: begin
          for (int unsigned i = 0; i < S; i++) begin
            if (idx_q == SW'(i)) begin
              delta_bus[i*DW +: DW] <= res;
              err_div0[i]           <= (dx_q == '0);
              err_sat[i]            <= (dx_q != '0) && quo_big;
            end
          end
          seg_delta <= res;
          seg_idx   <= idx_q;
          seg_valid <= 1'b1;
          if (last_seg) cal_valid <= 1'b1;
          else          idx_q     <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_piecewise_slope_gen.sv
// Testbench for piecewise_slope_gen (default parameters): table-driven segment
// vectors, randomized knot tables against an arithmetic reference model, and
// hand-written sequences for re-pulse, knot change, DONE restart and reset.
module tb_piecewise_slope_gen;

  localparam int NK = 16;
  localparam int NS = NK - 1;
  localparam int SEG_CYC = 22;

  logic             clock = 1'b0;
  logic             rst = 1'b0;
  logic             cal_begin = 1'b0;
  logic [NK*16-1:0] knot_x = '0;
  logic [NK*16-1:0] knot_y = '0;
  logic             busy, cal_valid, seg_valid;
  logic [NS*12-1:0] delta_bus;
  logic [3:0]       seg_idx;
  logic [11:0]      seg_delta;
  logic [NS-1:0]    err_div0, err_sat;

  piecewise_slope_gen dut (
    .clock(clock), .rst(rst), .cal_begin(cal_begin),
    .knot_x(knot_x), .knot_y(knot_y),
    .busy(busy), .cal_valid(cal_valid), .delta_bus(delta_bus),
    .seg_valid(seg_valid), .seg_idx(seg_idx), .seg_delta(seg_delta),
    .err_div0(err_div0), .err_sat(err_sat)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  int          kx[NK];
  int          ky[NK];
  logic [11:0] exp_d[NS];
  bit          exp_d0[NS];
  bit          exp_sat[NS];

  typedef struct {
    int          seg;
    int          dx;
    int          dy;
    logic [11:0] exp_delta;
    bit          exp_div0;
    bit          exp_sat;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slope from first principles: (dy*16)/dx truncated, clamped to +-2047
  function automatic void model_seg(input int x0, input int x1, input int y0, input int y1,
                                    output logic [11:0] d, output bit d0, output bit sat);
    int dy, dx, mag, q;
    dy  = y1 - y0;
    dx  = (x1 - x0) & 'hFFFF;
    mag = (dy < 0) ? -dy : dy;
    d0  = 0;
    sat = 0;
    if (dx == 0) begin
      d0 = 1;
      q  = (dy == 0) ? 0 : 2047;
    end else begin
      q = (mag * 16) / dx;
      if (q > 2047) begin
        q   = 2047;
        sat = 1;
      end
    end
    d = 12'((dy < 0) ? -q : q);
  endfunction

  task automatic drive_knots();
    for (int i = 0; i < NK; i++) begin
      knot_x[i*16 +: 16] = 16'(kx[i]);
      knot_y[i*16 +: 16] = 16'(ky[i]);
    end
  endtask

  task automatic build_knots(input int seg, input int dx, input int dy);
    kx[0] = 16;
    ky[0] = 5000;
    for (int i = 0; i < NS; i++) begin
      kx[i+1] = kx[i] + ((i == seg) ? dx : 16);
      ky[i+1] = ky[i] + ((i == seg) ? dy : 32);
    end
  endtask

  // Starts a run from the current kx/ky and follows it to cal_valid
  task automatic run_cal(input int repulse_at, input bit scramble);
    logic [NS*12-1:0] exp_bus;
    logic [NS-1:0]    exp_e0, exp_es;
    int  k;
    bit  done;
    for (int i = 0; i < NS; i++) begin
      model_seg(kx[i], kx[i+1], ky[i], ky[i+1], exp_d[i], exp_d0[i], exp_sat[i]);
      exp_bus[i*12 +: 12] = exp_d[i];
      exp_e0[i] = exp_d0[i];
      exp_es[i] = exp_sat[i];
    end
    drive_knots();
    @(negedge clock);
    cal_begin = 1'b1;
    @(posedge clock);
    #1;
    cal_begin = 1'b0;
    chk("start_cal_valid", 256'(cal_valid), 256'(0));
    chk("start_busy", 256'(busy), 256'(1));
    chk("start_flags", 256'({err_div0, err_sat, delta_bus}), 256'(0));
    k = 0;
    done = 0;
    for (int c = 1; c <= 400 && !done; c++) begin
      if (scramble && c == 1) begin
        knot_x = {8{$urandom()}};
        knot_y = {8{$urandom()}};
      end
      cal_begin = (c == repulse_at);
      @(posedge clock);
      #1;
      if (seg_valid) begin
        chk("seg_time", 256'(c), 256'((k + 1) * SEG_CYC));
        chk("seg_idx", 256'(seg_idx), 256'(k));
        if (k < NS) chk("seg_delta", 256'(seg_delta), 256'(exp_d[k]));
        k++;
      end
      if (cal_valid) begin
        done = 1;
        chk("cal_valid_time", 256'(c), 256'(NS * SEG_CYC));
        chk("seg_count", 256'(k), 256'(NS));
        chk("delta_bus", 256'(delta_bus), 256'(exp_bus));
        chk("err_div0", 256'(err_div0), 256'(exp_e0));
        chk("err_sat", 256'(err_sat), 256'(exp_es));
        chk("busy_done", 256'(busy), 256'(0));
      end
    end
    cal_begin = 1'b0;
    if (!done) chk("cal_timeout", 256'(0), 256'(1));
  endtask

  task automatic random_knots();
    int mode;
    mode = int'($urandom_range(0, 2));
    kx[0] = int'($urandom_range(0, 65535));
    ky[0] = 30000;
    for (int i = 0; i < NK; i++) begin
      if (mode == 0) begin
        kx[i] = int'($urandom_range(0, 65535));
        ky[i] = int'($urandom_range(0, 65535));
      end else if (i > 0) begin
        kx[i] = (kx[i-1] + int'($urandom_range(0, (mode == 1) ? 40 : 3))) & 'hFFFF;
        ky[i] = ky[i-1] + int'($urandom_range(0, 400)) - 200;
        if (ky[i] < 0) ky[i] = 0;
        if (ky[i] > 65535) ky[i] = 65535;
      end
    end
  endtask

  initial begin
    vecs[0] = '{3,  16, -8,    12'hFF8, 1'b0, 1'b0};
    vecs[1] = '{3,  3,  -1,    12'hFFB, 1'b0, 1'b0};
    vecs[2] = '{0,  1,  4096,  12'h7FF, 1'b0, 1'b1};
    vecs[3] = '{0,  1,  -4096, 12'h801, 1'b0, 1'b1};
    vecs[4] = '{5,  0,  5,     12'h7FF, 1'b1, 1'b0};
    vecs[5] = '{5,  0,  0,     12'h000, 1'b1, 1'b0};
    vecs[6] = '{7,  0,  -3,    12'h801, 1'b1, 1'b0};
    vecs[7] = '{14, 5,  7,     12'h016, 1'b0, 1'b0};
    vecs[8] = '{2,  1,  127,   12'h7F0, 1'b0, 1'b0};
    vecs[9] = '{2,  1,  128,   12'h7FF, 1'b0, 1'b1};

    // Reset state
    #2 rst = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outputs", 256'({busy, cal_valid, seg_valid, seg_idx, seg_delta,
                              err_div0, err_sat, delta_bus}), 256'(0));
    rst = 1'b0;

    // Uniform slope 2.0 on every segment
    for (int i = 0; i < NK; i++) begin
      kx[i] = 16 * (i + 1);
      ky[i] = 32 * i;
    end
    run_cal(0, 0);
    chk("uniform_bus", 256'(delta_bus), 256'({NS{12'h020}}));

    // Table vectors: one modified segment, the rest at slope 2.0
    foreach (vecs[v]) begin
      build_knots(vecs[v].seg, vecs[v].dx, vecs[v].dy);
      run_cal(0, 0);
      chk("vec_delta", 256'(delta_bus[vecs[v].seg*12 +: 12]), 256'(vecs[v].exp_delta));
      chk("vec_div0", 256'(err_div0[vecs[v].seg]), 256'(vecs[v].exp_div0));
      chk("vec_sat", 256'(err_sat[vecs[v].seg]), 256'(vecs[v].exp_sat));
    end

    // Re-pulse while busy and knot inputs changed after capture
    build_knots(4, 7, -100);
    run_cal(100, 1);

    // Randomized knot tables
    for (int r = 0; r < 10; r++) begin
      random_knots();
      run_cal(0, 0);
    end

    // Asynchronous reset mid-run, then a clean run
    build_knots(1, 9, 50);
    drive_knots();
    @(negedge clock);
    cal_begin = 1'b1;
    @(posedge clock);
    #1 cal_begin = 1'b0;
    repeat (149) @(posedge clock);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset", 256'({busy, cal_valid, seg_valid, seg_idx, seg_delta,
                              err_div0, err_sat, delta_bus}), 256'(0));
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("idle_after_reset", 256'({busy, cal_valid}), 256'(0));
    run_cal(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
